// File: rtl/hub75_shift_ext.sv
// HUB75 column shifter: reads one word per column from line RAM, selects a bit-plane
// per channel and generates the panel shift clock with a runtime divider and scan order.
module hub75_shift_ext #(
    parameter int N_BANKS    = 2,
    parameter int N_COLS     = 64,
    parameter int N_CHANS    = 3,
    parameter int N_PLANES   = 8,
    parameter int RAM_LAT    = 1,
    parameter int DIV_W      = 4,
    parameter int SDW        = N_BANKS * N_CHANS,
    parameter int LOG_N_COLS = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [SDW-1:0]            phy_data,
    output logic                      phy_clk,
    input  logic [SDW*N_PLANES-1:0]   ram_data,
    output logic [LOG_N_COLS-1:0]     ram_col_addr,
    output logic                      ram_rden,
    input  logic [N_PLANES-1:0]       ctrl_plane,
    input  logic [LOG_N_COLS-1:0]     ctrl_last_col,
    input  logic [DIV_W-1:0]          ctrl_div,
    input  logic                      ctrl_reverse,
    input  logic                      ctrl_go,
    output logic                      ctrl_rdy
);
    localparam int D = RAM_LAT + 1;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                  r_state;
    logic [DIV_W:0]          r_ph;
    logic [LOG_N_COLS-1:0]   r_col;
    logic [LOG_N_COLS-1:0]   r_last;
    logic [DIV_W-1:0]        r_div;
    logic                    r_rev;
    logic [N_PLANES-1:0]     r_plane;
    logic                    r_rden;
    logic [SDW-1:0]          r_data;
    logic [D-1:0]            r_act_d;
    logic [D-1:0]            r_hi_d;
    logic [RAM_LAT-1:0]      r_vld_d;

    logic                    w_accept;
    logic                    w_ph_end;
    logic                    w_col_end;
    logic                    w_hi;
    logic                    w_act;
    logic [SDW-1:0]          w_sel;

    assign w_accept  = ctrl_go && ctrl_rdy;
    // Last phase of a column is P-1 = 2*div+1.
    assign w_ph_end  = (r_ph == {r_div, 1'b1});
    assign w_col_end = r_rev ? (r_col == '0) : (r_col == r_last);
    assign w_hi      = (r_ph > {1'b0, r_div});
    assign w_act     = (r_state == S_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ph    <= '0;
            r_col   <= '0;
            r_last  <= '0;
            r_div   <= '0;
            r_rev   <= 1'b0;
            r_plane <= '0;
            r_rden  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rden <= 1'b0;
                    if (w_accept) begin
                        r_state <= S_SHIFT;
                        r_ph    <= '0;
                        r_col   <= ctrl_reverse ? ctrl_last_col : '0;
                        r_last  <= ctrl_last_col;
                        r_div   <= ctrl_div;
                        r_rev   <= ctrl_reverse;
                        r_plane <= ctrl_plane;
                        r_rden  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_ph_end) begin
                        r_ph <= '0;
                        if (w_col_end) begin
                            r_state <= S_IDLE;
                            r_rden  <= 1'b0;
                        end else begin
                            r_col  <= r_rev ? r_col - 1'b1 : r_col + 1'b1;
                            r_rden <= 1'b1;
                        end
                    end else begin
                        r_ph   <= r_ph + 1'b1;
                        r_rden <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Clock qualifiers travel D stages so the panel clock lines up with registered data.
    for (genvar gi = 0; gi < D; gi++) begin : g_clk_dly
        if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_act_d[gi] <= 1'b0;
                    r_hi_d[gi]  <= 1'b0;
                end else begin
                    r_act_d[gi] <= w_act;
                    r_hi_d[gi]  <= w_hi;
                end
            end
        end else begin : g_rest
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_act_d[gi] <= 1'b0;
                    r_hi_d[gi]  <= 1'b0;
                end else begin
                    r_act_d[gi] <= r_act_d[gi-1];
                    r_hi_d[gi]  <= r_hi_d[gi-1];
                end
            end
        end
    end

    for (genvar gi = 0; gi < RAM_LAT; gi++) begin : g_vld_dly
        if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (rst) r_vld_d[gi] <= 1'b0;
                else     r_vld_d[gi] <= r_rden;
            end
        end else begin : g_rest
            always_ff @(posedge clk) begin
                if (rst) r_vld_d[gi] <= 1'b0;
                else     r_vld_d[gi] <= r_vld_d[gi-1];
            end
        end
    end

    for (genvar gi = 0; gi < SDW; gi++) begin : g_sel
        assign w_sel[gi] = |(ram_data[gi*N_PLANES +: N_PLANES] & r_plane);
    end

    always_ff @(posedge clk) begin
        if (rst)                       r_data <= '0;
        else if (r_vld_d[RAM_LAT-1])   r_data <= w_sel;
    end

    assign phy_data     = r_data;
    assign phy_clk      = r_act_d[D-1] & r_hi_d[D-1];
    assign ram_rden     = r_rden;
    assign ram_col_addr = r_col;
    assign ctrl_rdy     = (r_state == S_IDLE) && !(|r_act_d);
endmodule

// File: tb/tb_hub75_shift_ext.sv
// Directed bench for hub75_shift_ext: one instance with RAM latency 1, one with latency 3,
// table-driven rows plus hand-written busy-go, reset-abort and back-to-back sequences.
module tb_hub75_shift_ext;
    localparam int NC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  c_plane;
    logic [2:0]  c_last;
    logic [3:0]  c_div;
    logic        c_rev;
    logic        go_a, go_b;

    logic [5:0]  a_data, b_data;
    logic        a_clk, b_clk, a_rden, b_rden, a_rdy, b_rdy;
    logic [2:0]  a_addr, b_addr;
    logic [47:0] a_ram, b_ram, b_p0, b_p1;
    logic [47:0] img [NC];

    hub75_shift_ext #(.N_COLS(NC), .RAM_LAT(1)) u_a (
        .clk(clk), .rst(rst), .phy_data(a_data), .phy_clk(a_clk), .ram_data(a_ram),
        .ram_col_addr(a_addr), .ram_rden(a_rden), .ctrl_plane(c_plane),
        .ctrl_last_col(c_last), .ctrl_div(c_div), .ctrl_reverse(c_rev),
        .ctrl_go(go_a), .ctrl_rdy(a_rdy));

    hub75_shift_ext #(.N_COLS(NC), .RAM_LAT(3)) u_b (
        .clk(clk), .rst(rst), .phy_data(b_data), .phy_clk(b_clk), .ram_data(b_ram),
        .ram_col_addr(b_addr), .ram_rden(b_rden), .ctrl_plane(c_plane),
        .ctrl_last_col(c_last), .ctrl_div(c_div), .ctrl_reverse(c_rev),
        .ctrl_go(go_b), .ctrl_rdy(b_rdy));

    // Line RAM models: data appears RAM_LAT cycles after the read strobe.
    always @(posedge clk) begin
        if (a_rden) a_ram <= img[a_addr];
        if (b_rden) b_p0  <= img[b_addr];
        b_p1  <= b_p0;
        b_ram <= b_p1;
    end

    logic        sel;
    logic [5:0]  m_data;
    logic        m_clk, m_rden, m_rdy;
    logic [2:0]  m_addr;
    always_comb begin
        if (sel) begin
            m_data = b_data; m_clk = b_clk; m_rden = b_rden; m_rdy = b_rdy; m_addr = b_addr;
        end else begin
            m_data = a_data; m_clk = a_clk; m_rden = a_rden; m_rdy = a_rdy; m_addr = a_addr;
        end
    end

    typedef struct {
        int         dut;
        int         last;
        int         div;
        int         rev;
        logic [7:0] plane;
        int         image;
        int         exp_rdy;
        int         exp_rise;
        int         use_const;
        logic [5:0] exp_const;
    } vec_t;

    vec_t vecs [9];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int t, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
        end
    endtask

    function automatic logic [47:0] tag(input int c);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[i*8 +: 8] = 8'(c*37 + i*11 + 5);
        return r;
    endfunction

    function automatic logic [5:0] exp_sel(input int c, input logic [7:0] pl);
        logic [5:0]  r;
        logic [47:0] w;
        w = tag(c);
        for (int i = 0; i < 6; i++) r[i] = |(w[i*8 +: 8] & pl);
        return r;
    endfunction

    task automatic load_img(input int image);
        for (int c = 0; c < NC; c++)
            img[c] = (image == 0) ? tag(c) : ((48'h1 << 5) | (48'h1 << 37));
    endtask

    task automatic wait_rdy(input string nm);
        int w = 0;
        while (!m_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk(nm, w, m_rdy, 1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int p, n, d, u, k, col, first_rdy, first_rise, rises;
        logic prev_clk, e_rden, e_clk;
        logic [5:0] ed;
        p = 2 * (v.div + 1);
        n = v.last + 1;
        d = v.dut ? 4 : 2;
        sel = (v.dut != 0);
        c_last = 3'(v.last); c_div = 4'(v.div); c_rev = (v.rev != 0); c_plane = v.plane;
        load_img(v.image);
        @(negedge clk);
        wait_rdy("idle_before_go");
        if (v.dut != 0) go_b = 1'b1; else go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0; go_b = 1'b0;
        // Scrambled controls must not affect the row already accepted.
        c_last = ~c_last; c_div = 4'hF; c_rev = ~c_rev; c_plane = ~c_plane;
        first_rdy = -1; first_rise = -1; rises = 0; prev_clk = 1'b0;
        for (int t = 1; t <= v.exp_rdy + 2; t++) begin
            e_rden = (t <= n*p) && (((t-1) % p) == 0);
            chk("rden", t, m_rden, e_rden);
            if (e_rden) chk("addr", t, m_addr, v.rev != 0 ? v.last - (t-1)/p : (t-1)/p);
            u = t - d;
            e_clk = (u >= 1) && (u <= n*p) && (((u-1) % p) >= v.div + 1);
            chk("phy_clk", t, m_clk, e_clk);
            if (u >= 1 && u <= n*p) begin
                k = (u-1) / p;
                col = (v.rev != 0) ? v.last - k : k;
                ed = (v.use_const != 0) ? v.exp_const : exp_sel(col, v.plane);
                chk("phy_data", t, m_data, ed);
            end
            chk("rdy", t, m_rdy, t >= 1 + n*p + d);
            if (m_rdy && first_rdy < 0) first_rdy = t;
            if (m_clk && !prev_clk) begin
                rises++;
                if (first_rise < 0) first_rise = t;
            end
            prev_clk = m_clk;
            @(negedge clk);
        end
        chk("first_rdy", id, first_rdy, v.exp_rdy);
        chk("first_rise", id, first_rise, v.exp_rise);
        chk("rise_count", id, rises, n);
        $display("vec %0d dut=%0d last=%0d div=%0d rev=%0d plane=%02h rdy_at=%0d rise_at=%0d",
                 id, v.dut, v.last, v.div, v.rev, v.plane, first_rdy, first_rise);
    endtask

    task automatic seq_busy();
        int nr, last_r;
        sel = 1'b0; c_last = 3'd1; c_div = 4'd0; c_rev = 1'b0; c_plane = 8'h01;
        load_img(0);
        wait_rdy("busy_idle");
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        nr = 0; last_r = 0;
        for (int t = 1; t <= 15; t++) begin
            if (a_rden) begin nr++; last_r = t; end
            go_a = (t >= 2 && t <= 4);
            @(negedge clk);
        end
        go_a = 1'b0;
        chk("busy_rden_count", 0, nr, 2);
        chk("busy_last_rden", 0, last_r, 3);
        $display("busy-go sequence rdens=%0d last=%0d", nr, last_r);
    endtask

    task automatic seq_reset();
        int nr, nc;
        sel = 1'b0; c_last = 3'd7; c_div = 4'd0; c_rev = 1'b0; c_plane = 8'h01;
        load_img(0);
        wait_rdy("rst_idle");
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_pre_rden", 7, a_rden, 1);
        chk("rst_pre_addr", 7, a_addr, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_data", 8, a_data, 0);
        chk("rst_clk", 8, a_clk, 0);
        chk("rst_rden", 8, a_rden, 0);
        chk("rst_addr", 8, a_addr, 0);
        chk("rst_rdy", 8, a_rdy, 1);
        rst = 1'b0;
        nr = 0; nc = 0;
        for (int t = 0; t < 20; t++) begin
            if (a_rden) nr++;
            if (a_clk) nc++;
            @(negedge clk);
        end
        chk("post_rst_rden", 0, nr, 0);
        chk("post_rst_clk", 0, nc, 0);
        $display("reset-abort sequence rdens=%0d clk_highs=%0d", nr, nc);
        run_vec(vecs[0], 100);
    endtask

    task automatic seq_b2b();
        int rd [$];
        int ry [$];
        int exp_rd [5] = '{1, 3, 10, 12, 19};
        sel = 1'b1; c_last = 3'd1; c_div = 4'd0; c_rev = 1'b0; c_plane = 8'h01;
        load_img(0);
        wait_rdy("b2b_idle");
        go_b = 1'b1;
        @(negedge clk);
        for (int t = 1; t <= 20; t++) begin
            if (b_rden) rd.push_back(t);
            if (b_rdy) ry.push_back(t);
            @(negedge clk);
        end
        go_b = 1'b0;
        chk("b2b_rden_count", 0, rd.size(), 5);
        for (int i = 0; i < 5 && i < rd.size(); i++) chk("b2b_rden_at", i, rd[i], exp_rd[i]);
        chk("b2b_rdy_count", 0, ry.size(), 2);
        if (ry.size() > 0) chk("b2b_rdy_first", 0, ry[0], 9);
        if (ry.size() > 1) chk("b2b_rdy_second", 0, ry[1], 18);
        $display("back-to-back sequence rdens=%0d rdy_pulses=%0d", rd.size(), ry.size());
        wait_rdy("b2b_drain");
    endtask

    initial begin
        vecs[0] = '{0, 7, 0, 0, 8'h01, 0, 19, 4, 0, 6'h00};
        vecs[1] = '{0, 1, 2, 0, 8'h02, 0, 15, 6, 0, 6'h00};
        vecs[2] = '{0, 5, 0, 1, 8'h06, 0, 15, 4, 0, 6'h00};
        vecs[3] = '{0, 3, 1, 0, 8'h20, 1, 19, 5, 1, 6'b010001};
        vecs[4] = '{0, 3, 0, 0, 8'h01, 1, 11, 4, 1, 6'b000000};
        vecs[5] = '{0, 0, 0, 0, 8'h80, 0, 5, 4, 0, 6'h00};
        vecs[6] = '{1, 7, 0, 0, 8'h08, 0, 21, 6, 0, 6'h00};
        vecs[7] = '{1, 2, 3, 1, 8'h11, 0, 29, 9, 0, 6'h00};
        vecs[8] = '{1, 4, 1, 1, 8'h40, 0, 25, 7, 0, 6'h00};

        rst = 1'b1; go_a = 1'b0; go_b = 1'b0; sel = 1'b0;
        c_plane = 8'h00; c_last = 3'd0; c_div = 4'd0; c_rev = 1'b0;
        load_img(0);
        repeat (3) @(negedge clk);
        chk("reset_a_data", 0, a_data, 0);
        chk("reset_a_clk", 0, a_clk, 0);
        chk("reset_a_rden", 0, a_rden, 0);
        chk("reset_a_addr", 0, a_addr, 0);
        chk("reset_a_rdy", 0, a_rdy, 1);
        chk("reset_b_data", 0, b_data, 0);
        chk("reset_b_clk", 0, b_clk, 0);
        chk("reset_b_rden", 0, b_rden, 0);
        chk("reset_b_addr", 0, b_addr, 0);
        chk("reset_b_rdy", 0, b_rdy, 1);
        $display("reset state checked");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);
        seq_busy();
        seq_reset();
        seq_b2b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
